// File: rtl/rv32i_types.sv
// Shared rv32i encodings for the load/store unit.
// Holds load/store funct3 enums plus mbe, store-data and fault helpers.
package rv32i_types;

    typedef enum logic [2:0] {
        F3_LB  = 3'b000,
        F3_LH  = 3'b001,
        F3_LW  = 3'b010,
        F3_LBU = 3'b100,
        F3_LHU = 3'b101
    } load_funct3_t;

    typedef enum logic [2:0] {
        F3_SB = 3'b000,
        F3_SH = 3'b001,
        F3_SW = 3'b010
    } store_funct3_t;

    // funct3[1:0] encodes the access width for both loads and stores
    localparam logic [1:0] W_BYTE = 2'b00;
    localparam logic [1:0] W_HALF = 2'b01;
    localparam logic [1:0] W_WORD = 2'b10;

    function automatic logic [3:0] lsu_mbe(
        input logic [1:0] width,
        input logic [1:0] off
    );
        logic [3:0] mbe;
        unique case (width)
            W_BYTE:  mbe = 4'b0001 << off;
            W_HALF:  mbe = 4'b0011 << {off[1], 1'b0};
            default: mbe = 4'b1111;
        endcase
        return mbe;
    endfunction

    function automatic logic [31:0] lsu_wdata(
        input logic [1:0]  width,
        input logic [31:0] sd
    );
        logic [31:0] wd;
        unique case (width)
            W_BYTE:  wd = {4{sd[7:0]}};
            W_HALF:  wd = {2{sd[15:0]}};
            default: wd = sd;
        endcase
        return wd;
    endfunction

    function automatic logic lsu_fault(
        input logic       is_load,
        input logic [2:0] f3,
        input logic [1:0] off
    );
        logic bad_f3;
        logic misal;
        if (is_load) begin
            bad_f3 = !(f3 == F3_LB  || f3 == F3_LH  ||
                       f3 == F3_LW  || f3 == F3_LBU ||
                       f3 == F3_LHU);
        end else begin
            bad_f3 = !(f3 == F3_SB || f3 == F3_SH ||
                       f3 == F3_SW);
        end
        unique case (f3[1:0])
            W_HALF:  misal = off[0];
            W_WORD:  misal = (off != 2'b00);
            default: misal = 1'b0;
        endcase
        return bad_f3 | misal;
    endfunction

endpackage

// File: rtl/load_align.sv
// Load data aligner: shifts the memory word to the addressed lane and
// extends it. Ports: rdata/offset/funct3 in, result out (combinational).
module load_align (
    input  logic [31:0] rdata,
    input  logic [1:0]  offset,
    input  logic [2:0]  funct3,
    output logic [31:0] result
);
    import rv32i_types::*;

    logic [31:0] shifted;

    always_comb begin
        shifted = rdata >> {offset, 3'b000};
        result  = '0;
        unique case (funct3)
            F3_LB:   result = {{24{shifted[7]}}, shifted[7:0]};
            F3_LH:   result = {{16{shifted[15]}}, shifted[15:0]};
            F3_LW:   result = shifted;
            F3_LBU:  result = {24'h0, shifted[7:0]};
            F3_LHU:  result = {16'h0, shifted[15:0]};
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/mem_lsu.sv
// MEM-stage load/store unit: drives the data-memory port, stalls until
// the response, returns aligned load data.
// Ports: clk/rst; mem_read/mem_write/funct3/addr/store_data request in;
// stall/load_data/access_fault to pipeline; dmem_* memory port.
module mem_lsu (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    output logic        stall,
    output logic [31:0] load_data,
    output logic        access_fault,
    output logic [31:0] dmem_address,
    output logic        dmem_read,
    output logic        dmem_write,
    output logic [3:0]  dmem_mbe,
    output logic [31:0] dmem_wdata,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_resp
);
    import rv32i_types::*;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] address_q, address_d;
    logic        read_q, read_d;
    logic        write_q, write_d;
    logic [3:0]  mbe_q, mbe_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] load_data_q, load_data_d;
    logic        fault_q, fault_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [1:0]  off_q, off_d;

    logic        is_req;
    logic        is_load;
    logic        fault;
    logic [31:0] aligned;

    load_align u_align (
        .rdata  (dmem_rdata),
        .offset (off_q),
        .funct3 (funct3_q),
        .result (aligned)
    );

    always_comb begin
        // a simultaneous read and write is treated as a load
        is_load     = mem_read;
        is_req      = mem_read | mem_write;
        fault       = lsu_fault(is_load, funct3, addr[1:0]);

        state_d     = state_q;
        address_d   = address_q;
        read_d      = read_q;
        write_d     = write_q;
        mbe_d       = mbe_q;
        wdata_d     = wdata_q;
        funct3_d    = funct3_q;
        off_d       = off_q;
        load_data_d = '0;
        fault_d     = 1'b0;
        stall       = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (is_req) begin
                    stall    = 1'b1;
                    funct3_d = funct3;
                    off_d    = addr[1:0];
                    if (fault) begin
                        fault_d = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        state_d   = S_BUSY;
                        address_d = {addr[31:2], 2'b00};
                        read_d    = is_load;
                        write_d   = !is_load;
                        mbe_d     = lsu_mbe(funct3[1:0], addr[1:0]);
                        wdata_d   = is_load ? 32'h0
                                  : lsu_wdata(funct3[1:0], store_data);
                    end
                end
            end
            S_BUSY: begin
                stall = 1'b1;
                if (dmem_resp) begin
                    read_d  = 1'b0;
                    write_d = 1'b0;
                    state_d = S_DONE;
                    if (read_q) begin
                        load_data_d = aligned;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            address_q   <= '0;
            read_q      <= 1'b0;
            write_q     <= 1'b0;
            mbe_q       <= '0;
            wdata_q     <= '0;
            load_data_q <= '0;
            fault_q     <= 1'b0;
            funct3_q    <= '0;
            off_q       <= '0;
        end else begin
            state_q     <= state_d;
            address_q   <= address_d;
            read_q      <= read_d;
            write_q     <= write_d;
            mbe_q       <= mbe_d;
            wdata_q     <= wdata_d;
            load_data_q <= load_data_d;
            fault_q     <= fault_d;
            funct3_q    <= funct3_d;
            off_q       <= off_d;
        end
    end

    assign dmem_address = address_q;
    assign dmem_read    = read_q;
    assign dmem_write   = write_q;
    assign dmem_mbe     = mbe_q;
    assign dmem_wdata   = wdata_q;
    assign load_data    = load_data_q;
    assign access_fault = fault_q;

endmodule

// File: tb/tb_mem_lsu.sv
// Self-checking bench for mem_lsu: transaction-level model of the
// expected per-cycle port behaviour plus literal spot checks.
module tb_mem_lsu;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_read, mem_write;
    logic [2:0]  funct3;
    logic [31:0] addr, store_data;
    logic        stall;
    logic [31:0] load_data;
    logic        access_fault;
    logic [31:0] dmem_address;
    logic        dmem_read, dmem_write;
    logic [3:0]  dmem_mbe;
    logic [31:0] dmem_wdata;
    logic [31:0] dmem_rdata;
    logic        dmem_resp;

    mem_lsu dut (
        .clk          (clk),
        .rst          (rst),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .funct3       (funct3),
        .addr         (addr),
        .store_data   (store_data),
        .stall        (stall),
        .load_data    (load_data),
        .access_fault (access_fault),
        .dmem_address (dmem_address),
        .dmem_read    (dmem_read),
        .dmem_write   (dmem_write),
        .dmem_mbe     (dmem_mbe),
        .dmem_wdata   (dmem_wdata),
        .dmem_rdata   (dmem_rdata),
        .dmem_resp    (dmem_resp)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    logic        chk_en = 1'b0;
    logic        bus_chk = 1'b0;
    logic        e_stall, e_rd, e_wr, e_fault;
    logic [31:0] e_addr, e_wdata, e_load;
    logic [3:0]  e_mbe;

    int          stall_cnt;
    logic [31:0] last_load, last_addr, last_wdata;
    logic [3:0]  last_mbe;
    logic        last_fault;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int m_size(input logic [2:0] f3);
        case (f3[1:0])
            2'b00:   return 1;
            2'b01:   return 2;
            default: return 4;
        endcase
    endfunction

    function automatic bit m_fault(input bit ld, input logic [2:0] f3,
                                   input logic [1:0] off);
        bit legal;
        if (ld) legal = (f3 != 3'b011) && (f3 != 3'b110) && (f3 != 3'b111);
        else    legal = (f3 <= 3'b010);
        if (!legal) return 1'b1;
        return (int'(off) % m_size(f3)) != 0;
    endfunction

    function automatic logic [3:0] m_mbe(input logic [2:0] f3,
                                         input logic [1:0] off);
        return 4'(((1 << m_size(f3)) - 1) << off);
    endfunction

    function automatic logic [31:0] m_wdata(input logic [2:0] f3,
                                            input logic [31:0] sd);
        case (m_size(f3))
            1:       return 32'(sd[7:0]) * 32'h0101_0101;
            2:       return 32'(sd[15:0]) * 32'h0001_0001;
            default: return sd;
        endcase
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] f3,
                                           input logic [1:0] off,
                                           input logic [31:0] rdata);
        logic [31:0] v, mask;
        int bits;
        if (m_size(f3) == 4) return rdata;
        bits = 8 * m_size(f3);
        v    = rdata >> (8 * int'(off));
        mask = (32'd1 << bits) - 32'd1;
        v    = v & mask;
        if (!f3[2] && v[bits-1]) v = v | ~mask;
        return v;
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            chk("stall",        32'(stall),        32'(e_stall));
            chk("dmem_read",    32'(dmem_read),    32'(e_rd));
            chk("dmem_write",   32'(dmem_write),   32'(e_wr));
            chk("load_data",    load_data,         e_load);
            chk("access_fault", 32'(access_fault), 32'(e_fault));
            if (e_rd || e_wr || bus_chk) begin
                chk("dmem_address", dmem_address, e_addr);
                chk("dmem_mbe",     32'(dmem_mbe), 32'(e_mbe));
            end
            if (e_wr || bus_chk) begin
                chk("dmem_wdata", dmem_wdata, e_wdata);
            end
            if (stall) stall_cnt++;
        end
    end

    task automatic set_exp(input logic s, input logic r, input logic w,
                           input logic [31:0] ld, input logic f);
        e_stall = s;
        e_rd    = r;
        e_wr    = w;
        e_load  = ld;
        e_fault = f;
    endtask

    task automatic step();
        @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n, input logic resp);
        mem_read  = 1'b0;
        mem_write = 1'b0;
        dmem_resp = resp;
        set_exp(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        for (int i = 0; i < n; i++) step();
        dmem_resp = 1'b0;
    endtask

    // One instruction in MEM; resp arrives on cycle k (k>=1) and is
    // also held through DONE, where it must be ignored.
    task automatic txn(input bit rd, input bit wr, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] sd,
                       input logic [31:0] rdat, input int k);
        bit ld;
        bit flt;
        int last;
        ld  = rd;
        flt = m_fault(ld, f3, a[1:0]);
        mem_read   = rd;
        mem_write  = wr;
        funct3     = f3;
        addr       = a;
        store_data = sd;
        dmem_rdata = rdat;
        e_addr     = {a[31:2], 2'b00};
        e_mbe      = m_mbe(f3, a[1:0]);
        e_wdata    = m_wdata(f3, sd);
        stall_cnt  = 0;
        last       = flt ? 1 : k + 1;
        for (int c = 0; c <= last; c++) begin
            dmem_resp = !flt && (c == k || c == k + 1);
            if (c == last)
                set_exp(1'b0, 1'b0, 1'b0,
                        (flt || !ld) ? 32'h0 : m_load(f3, a[1:0], rdat),
                        flt);
            else if (c == 0 || flt)
                set_exp(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
            else
                set_exp(1'b1, ld, !ld, 32'h0, 1'b0);
            @(negedge clk);
            if (c == 1 && !flt) begin
                last_mbe   = dmem_mbe;
                last_wdata = dmem_wdata;
                last_addr  = dmem_address;
            end
            if (c == last) begin
                last_load  = load_data;
                last_fault = access_fault;
            end
            @(posedge clk);
            #1;
        end
        dmem_resp = 1'b0;
    endtask

    initial begin
        rst        = 1'b1;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        funct3     = 3'b000;
        addr       = 32'h0;
        store_data = 32'h0;
        dmem_rdata = 32'h0;
        dmem_resp  = 1'b0;
        stall_cnt  = 0;

        chk("pin_lb",  m_load(3'b000, 2'd3, 32'h80FF_1234), 32'hFFFF_FF80);
        chk("pin_lbu", m_load(3'b100, 2'd3, 32'h80FF_1234), 32'h0000_0080);
        chk("pin_lh",  m_load(3'b001, 2'd2, 32'h8001_7FFE), 32'hFFFF_8001);
        chk("pin_mbe", 32'(m_mbe(3'b001, 2'd2)), 32'hC);
        chk("pin_wd",  m_wdata(3'b001, 32'h0000_BEEF), 32'hBEEF_BEEF);
        chk("pin_flt", 32'(m_fault(1'b1, 3'b010, 2'd2)), 32'h1);

        @(posedge clk);
        @(posedge clk);
        #1;
        chk_en  = 1'b1;
        bus_chk = 1'b1;
        e_addr  = 32'h0;
        e_mbe   = 4'h0;
        e_wdata = 32'h0;
        set_exp(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        step();
        rst = 1'b0;
        idle(1, 1'b0);
        bus_chk = 1'b0;

        txn(1, 0, 3'b000, 32'h0000_1003, 32'h0, 32'h80FF_1234, 1);
        chk("lb_lit", last_load, 32'hFFFF_FF80);
        txn(1, 0, 3'b100, 32'h0000_1003, 32'h0, 32'h80FF_1234, 1);
        chk("lbu_lit", last_load, 32'h0000_0080);

        txn(0, 1, 3'b001, 32'h0000_2002, 32'h0000_BEEF, 32'h0, 2);
        chk("sh_mbe",  32'(last_mbe), 32'hC);
        chk("sh_wd",   last_wdata, 32'hBEEF_BEEF);
        chk("sh_addr", last_addr,  32'h0000_2000);
        chk("sh_load", last_load,  32'h0);

        txn(1, 0, 3'b010, 32'h0000_3000, 32'h0, 32'hDEAD_BEEF, 5);
        chk("lw_stall_cycles", 32'(stall_cnt), 32'd6);
        chk("lw_lit", last_load, 32'hDEAD_BEEF);

        txn(1, 0, 3'b010, 32'h0000_3002, 32'h0, 32'hDEAD_BEEF, 1);
        chk("flt_stall_cycles", 32'(stall_cnt), 32'd1);
        chk("flt_pulse", 32'(last_fault), 32'h1);
        chk("flt_load",  last_load, 32'h0);

        idle(2, 1'b1);

        txn(1, 0, 3'b001, 32'h0000_0012, 32'h0, 32'h8001_7FFE, 1);
        txn(1, 0, 3'b101, 32'h0000_0012, 32'h0, 32'h8001_7FFE, 2);
        txn(1, 0, 3'b000, 32'h0000_9002, 32'h0, 32'h1234_5678, 1);
        txn(1, 0, 3'b101, 32'h0000_0010, 32'h0, 32'h8001_7FFE, 1);
        txn(0, 1, 3'b000, 32'h0000_5001, 32'h0000_00A5, 32'h0, 1);
        chk("sb_mbe", 32'(last_mbe), 32'h2);
        chk("sb_wd",  last_wdata, 32'hA5A5_A5A5);
        txn(0, 1, 3'b010, 32'h0000_6000, 32'h1234_5678, 32'h0, 3);
        txn(1, 1, 3'b010, 32'h0000_7000, 32'hFFFF_FFFF, 32'hCAFE_F00D, 1);
        chk("rw_read_wins", last_load, 32'hCAFE_F00D);
        txn(0, 1, 3'b001, 32'h0000_7001, 32'h1111, 32'h0, 1);
        txn(1, 0, 3'b011, 32'h0000_0000, 32'h0, 32'h0, 1);
        txn(1, 0, 3'b110, 32'h0000_0000, 32'h0, 32'h0, 1);
        txn(0, 1, 3'b100, 32'h0000_0000, 32'h55, 32'h0, 1);
        chk("st_f3_flt", 32'(last_fault), 32'h1);
        idle(1, 1'b0);

        mem_read   = 1'b1;
        mem_write  = 1'b0;
        funct3     = 3'b010;
        addr       = 32'h0000_4000;
        dmem_rdata = 32'h55AA_55AA;
        e_addr     = 32'h0000_4000;
        e_mbe      = 4'hF;
        set_exp(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        step();
        set_exp(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
        step();
        rst = 1'b1;
        step();
        rst       = 1'b0;
        mem_read  = 1'b0;
        dmem_resp = 1'b1;
        bus_chk   = 1'b1;
        e_addr    = 32'h0;
        e_mbe     = 4'h0;
        e_wdata   = 32'h0;
        set_exp(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        step();
        dmem_resp = 1'b0;
        step();
        bus_chk = 1'b0;

        txn(1, 0, 3'b010, 32'h0000_0100, 32'h0, 32'h1111_1111, 1);
        txn(1, 0, 3'b010, 32'h0000_0104, 32'h0, 32'h2222_2222, 1);
        chk("b2b_second", last_load, 32'h2222_2222);
        idle(2, 1'b0);

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
